// File: rtl/ysyx_25020047_mem_arbiter.sv
// Two-to-one arbiter sharing the data-memory port between IFU (read-only) and LSU.
// One transaction in flight, round-robin on contention, timeout completes stuck transfers.
module ysyx_25020047_mem_arbiter #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_resp_valid,
  output logic [31:0] ifu_rdata,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_resp_valid,
  output logic [31:0] lsu_rdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wen,
  output logic [3:0]  mem_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata,
  output logic        bus_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e          r_state;
  state_e          w_next;
  logic            r_owner;
  logic            r_last_grant;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic            r_wen;
  logic [3:0]      r_wmask;
  logic [CntW-1:0] r_cnt;
  logic            r_bus_err;

  logic            w_grant_lsu;
  logic            w_accept;
  logic            w_timeout;
  logic            w_phase_done;
  logic            w_resp;
  logic [31:0]     w_resp_data;

  // Arbitration and phase decode; LSU wins only when IFU is idle or IFU was served last
  always_comb begin
    w_grant_lsu  = lsu_req_valid & (~ifu_req_valid | ~r_last_grant);
    w_accept     = ~rst & (r_state == IDLE) & (ifu_req_valid | lsu_req_valid);
    w_timeout    = ((r_state == REQ) | (r_state == RESP)) & (r_cnt == CntW'(TIMEOUT));
    w_phase_done = ((r_state == REQ) & mem_req_ready) | ((r_state == RESP) & mem_resp_valid);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = REQ;
      REQ: begin
        if (w_timeout)          w_next = IDLE;
        else if (mem_req_ready) w_next = RESP;
      end
      RESP:    if (w_timeout || mem_resp_valid) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Request capture, watchdog counter and sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_addr       <= 32'h0;
      r_wdata      <= 32'h0;
      r_wen        <= 1'b0;
      r_wmask      <= 4'h0;
      r_cnt        <= '0;
      r_bus_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_owner      <= w_grant_lsu;
        r_last_grant <= w_grant_lsu;
        r_addr       <= w_grant_lsu ? lsu_addr  : ifu_addr;
        r_wdata      <= w_grant_lsu ? lsu_wdata : 32'h0;
        r_wen        <= w_grant_lsu & lsu_wen;
        r_wmask      <= w_grant_lsu ? lsu_wmask : 4'h0;
      end
      case (r_state)
        REQ, RESP: r_cnt <= (w_timeout || w_phase_done) ? '0 : r_cnt + CntW'(1);
        default:   r_cnt <= '0;
      endcase
      if (w_timeout) r_bus_err <= 1'b1;
    end
  end

  // A timeout masquerades as a zero-data response so the owner never stalls forever
  always_comb begin
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    ifu_resp_valid = 1'b0;
    ifu_rdata      = 32'h0;
    lsu_resp_valid = 1'b0;
    lsu_rdata      = 32'h0;
    mem_req_valid  = (r_state == REQ);
    mem_addr       = r_addr;
    mem_wdata      = r_wdata;
    mem_wen        = r_wen;
    mem_wmask      = r_wmask;
    w_resp         = ((r_state == RESP) & mem_resp_valid) | w_timeout;
    w_resp_data    = w_timeout ? 32'h0 : mem_rdata;
    if (w_accept) begin
      ifu_req_ready = ~w_grant_lsu;
      lsu_req_ready = w_grant_lsu;
    end
    if (w_resp) begin
      if (r_owner) begin
        lsu_resp_valid = 1'b1;
        lsu_rdata      = w_resp_data;
      end else begin
        ifu_resp_valid = 1'b1;
        ifu_rdata      = w_resp_data;
      end
    end
  end

  assign bus_err = r_bus_err;

endmodule

// File: tb/tb_ysyx_25020047_mem_arbiter.sv
// Directed bench for the memory arbiter: expected transactions are queued at issue and
// checked against the memory-side request and the requester-side response.
module tb_ysyx_25020047_mem_arbiter;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        bus_err;

  ysyx_25020047_mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        owner;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;
  int acc_cyc = 0;
  int resp_cyc = 0;
  int waited;

  logic        s_ifu_ready, s_lsu_ready, s_ifu_resp, s_lsu_resp, s_mem_req_valid, s_bus_err;

  // Memory model knobs and state
  int          cfg_ready_lat = 0;
  bit          cfg_never_ready = 1'b0;
  bit          cfg_no_resp = 1'b0;
  bit          f_resp = 1'b0;
  bit          m_pend = 1'b0;
  int          m_wait = 0;
  logic [31:0] m_data = 32'h0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0010_0073;
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive memory, sample at negedge, score, return at posedge+1
  task automatic cyc();
    exp_t e;
    mem_req_ready  = mem_req_valid && !cfg_never_ready && (m_wait >= cfg_ready_lat);
    mem_resp_valid = f_resp || (m_pend && !cfg_no_resp);
    mem_rdata      = mem_resp_valid ? m_data : $urandom;
    @(negedge clk);
    s_ifu_ready     = ifu_req_ready;
    s_lsu_ready     = lsu_req_ready;
    s_ifu_resp      = ifu_resp_valid;
    s_lsu_resp      = lsu_resp_valid;
    s_mem_req_valid = mem_req_valid;
    s_bus_err       = bus_err;
    if (rst == 1'b0) begin
      if (ifu_req_ready || lsu_req_ready) begin
        acc_cyc = cyc_n;
        chk("single_ready", 72'({ifu_req_ready, lsu_req_ready} == 2'b11), 72'(0));
      end
      if (mem_resp_valid) m_pend = 1'b0;
      if (mem_req_valid) begin
        if (sb.size() == 0) chk("mem_req_without_txn", 72'(1), 72'(0));
        else begin
          e = sb[0];
          chk("mem_req_fields", 72'({mem_addr, mem_wen, mem_wdata, mem_wmask}),
              72'({e.addr, e.wen, e.wdata, e.wmask}));
        end
        if (mem_req_ready) begin
          m_pend = 1'b1;
          m_data = memf(mem_addr);
          m_wait = 0;
        end else m_wait++;
      end
      if (ifu_resp_valid || lsu_resp_valid) begin
        resp_cyc = cyc_n;
        if (sb.size() == 0) chk("unexpected_resp", 72'({ifu_resp_valid, lsu_resp_valid}), 72'(0));
        else begin
          e = sb.pop_front();
          chk("resp_owner", 72'({ifu_resp_valid, lsu_resp_valid}), 72'(e.owner ? 2'b01 : 2'b10));
          chk("resp_rdata", 72'(e.owner ? lsu_rdata : ifu_rdata), 72'(e.rdata));
        end
      end
      if (!ifu_resp_valid) chk("ifu_rdata_gated", 72'(ifu_rdata), 72'(0));
      if (!lsu_resp_valid) chk("lsu_rdata_gated", 72'(lsu_rdata), 72'(0));
    end
    cyc_n++;
    @(posedge clk);
    #1;
  endtask

  task automatic req(input bit lsu, input logic [31:0] a, input bit wen, input logic [31:0] wd,
                     input logic [3:0] wm, input logic [31:0] exp_rdata, output int w);
    exp_t e;
    bit   got;
    e.owner = lsu;
    e.addr  = a;
    e.wen   = lsu & wen;
    e.wdata = lsu ? wd : 32'h0;
    e.wmask = lsu ? wm : 4'h0;
    e.rdata = exp_rdata;
    sb.push_back(e);
    if (lsu) begin
      lsu_req_valid = 1'b1; lsu_addr = a; lsu_wen = wen; lsu_wdata = wd; lsu_wmask = wm;
    end else begin
      ifu_req_valid = 1'b1; ifu_addr = a;
    end
    got = 1'b0;
    w = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (lsu ? s_lsu_ready : s_ifu_ready) begin
        got = 1'b1;
        w = i;
        break;
      end
    end
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    if (!got) chk("grant_timeout", 72'(0), 72'(1));
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0) break;
      cyc();
    end
    chk("drain_empty", 72'(sb.size()), 72'(0));
  endtask

  initial begin
    rst = 1'b1;
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_2000; lsu_wen = 1'b0;
    lsu_wdata = 32'h0; lsu_wmask = 4'h0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'h0;
    #1;
    cyc();
    cyc();
    chk("rst_ready", 72'({s_ifu_ready, s_lsu_ready}), 72'(0));
    chk("rst_valids", 72'({s_ifu_resp, s_lsu_resp, s_mem_req_valid}), 72'(0));
    chk("rst_bus_err", 72'(s_bus_err), 72'(0));

    // First cycle out of reset: IFU wins the tie
    begin
      exp_t e;
      e.owner = 1'b0; e.addr = 32'h8000_0000; e.wen = 1'b0; e.wdata = 32'h0; e.wmask = 4'h0;
      e.rdata = 32'h0010_0073;
      sb.push_back(e);
    end
    rst = 1'b0;
    cyc();
    chk("first_ifu_ready", 72'(s_ifu_ready), 72'(1));
    chk("first_lsu_ready", 72'(s_lsu_ready), 72'(0));
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    drain(10);
    chk("ifu_read_span", 72'(resp_cyc - acc_cyc), 72'(2));
    cyc();
    chk("ifu_resp_one_cycle", 72'(s_ifu_resp), 72'(0));

    // LSU byte write with memory stalling the request
    cfg_ready_lat = 5;
    req(1'b1, 32'h8000_1003, 1'b1, 32'h1234_5678, 4'b0001, memf(32'h8000_1003), waited);
    drain(30);
    chk("lsu_write_span", 72'(resp_cyc - acc_cyc), 72'(7));
    cfg_ready_lat = 0;
    cyc();
    chk("lsu_resp_one_cycle", 72'(s_lsu_resp), 72'(0));

    // Continuous contention: grants alternate starting with IFU
    for (int k = 0; k < 6; k++) begin
      exp_t e;
      e.owner = k[0];
      e.addr  = k[0] ? 32'h8000_3000 : 32'h8000_0100;
      e.wen   = 1'b0;
      e.wdata = k[0] ? 32'hDEAD_BEEF : 32'h0;
      e.wmask = k[0] ? 4'hF : 4'h0;
      e.rdata = memf(e.addr);
      sb.push_back(e);
    end
    ifu_addr = 32'h8000_0100;
    lsu_addr = 32'h8000_3000; lsu_wen = 1'b0; lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    drain(40);
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    cyc();

    // Memory accepts but never responds: timeout in RESP
    cfg_no_resp = 1'b1;
    req(1'b0, 32'h8000_0200, 1'b0, 32'h0, 4'h0, 32'h0, waited);
    drain(20);
    chk("resp_timeout_span", 72'(resp_cyc - acc_cyc), 72'(TO + 2));
    cyc();
    chk("bus_err_set", 72'(s_bus_err), 72'(1));
    cfg_no_resp = 1'b0;
    m_pend = 1'b0;
    req(1'b0, 32'h8000_0300, 1'b0, 32'h0, 4'h0, memf(32'h8000_0300), waited);
    chk("grant_after_timeout", 72'(waited), 72'(0));
    drain(10);
    cyc();
    chk("bus_err_sticky", 72'(s_bus_err), 72'(1));

    // Memory never readies: timeout in REQ after TIMEOUT+1 cycles
    cfg_never_ready = 1'b1;
    req(1'b1, 32'h8000_4000, 1'b0, 32'h0, 4'h0, 32'h0, waited);
    drain(20);
    chk("req_timeout_span", 72'(resp_cyc - acc_cyc), 72'(TO + 1));
    cyc();
    chk("req_dropped_after_timeout", 72'(s_mem_req_valid), 72'(0));
    cfg_never_ready = 1'b0;

    // Reset while in RESP, then a late memory response
    cfg_no_resp = 1'b1;
    req(1'b0, 32'h8000_0400, 1'b0, 32'h0, 4'h0, memf(32'h8000_0400), waited);
    cyc();
    rst = 1'b1;
    sb.delete();
    m_pend = 1'b0;
    cyc();
    chk("rst_mid_resp_valids", 72'({s_ifu_resp, s_lsu_resp}), 72'(0));
    chk("rst_clears_bus_err", 72'(s_bus_err), 72'(0));
    rst = 1'b0;
    cfg_no_resp = 1'b0;
    f_resp = 1'b1;
    m_data = 32'hCAFE_F00D;
    cyc();
    f_resp = 1'b0;
    chk("late_resp_ignored", 72'({s_ifu_resp, s_lsu_resp}), 72'(0));
    chk("late_resp_idle", 72'({s_mem_req_valid, s_bus_err}), 72'(0));
    req(1'b0, 32'h8000_0500, 1'b0, 32'h0, 4'h0, memf(32'h8000_0500), waited);
    chk("idle_after_rst", 72'(waited), 72'(0));
    drain(10);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
